imem_loader: RTL and testbench

Program loader for the byte-addressable instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes each word as four bytes, big-endian, into the memory's byte write port, so that a later fetch at byte address A returns {mem[A],mem[A+1],mem[A+2],mem[A+3]}. The loader holds the CPU fetch stage in stall while a load is in progress. It sits between the boot/debug source and the instruction memory, on the write side of the port that fetch reads from.

---
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the byte-addressable instruction memory. It takes 32-bit
// instruction words from a valid/ready stream and writes each one as four
// bytes, big-endian, through the memory's byte write port. A fetch at byte
// address A then returns {mem[A], mem[A+1], mem[A+2], mem[A+3]}. While a load
// is in progress the CPU fetch stage is held off through cpu_hold.
//
// Parameters
//   MEM_SIZE    memory depth in bytes (valid addresses 0..MEM_SIZE-1)
//   CNT_W       width of word_count
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       one-cycle pulse that begins a load (ignored while busy)
//   base_addr   byte address of the first word, sampled on start
//   word_count  number of words to load, sampled on start
//   in_valid    in_data carries a word
//   in_data     instruction word; [31:24] lands at the lowest address
//   in_ready    loader accepts a word this cycle
//   mem_we      byte write enable
//   mem_addr    byte write address
//   mem_wdata   byte write data
//   busy        load in progress (any state other than IDLE)
//   cpu_hold    copy of busy, stalls fetch
//   done        one-cycle pulse on successful completion
//   error       sticky error flag, cleared by the next accepted start or rst
//
// Every output is either a register or decoded from registered state only,
// so there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MEM_SIZE = 511,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Highest legal byte address, widened to 33 bits for the range check.
  localparam logic [32:0] LAST_ADDR = 33'(MEM_SIZE - 1);

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic             error_q, error_d;

  // The last byte of the word about to be accepted lives at addr+3. Doing the
  // add in 33 bits makes a base near 2^32 fail instead of wrapping to a small
  // (apparently legal) address.
  logic [32:0] word_end;
  logic        out_of_range;

  assign word_end     = {1'b0, addr_q} + 33'd3;
  assign out_of_range = (word_end > LAST_ADDR);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      error_q     <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    data_d      = data_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Any start taken from IDLE clears the sticky flag; the misaligned
          // branch sets it straight back.
          error_d = 1'b0;
          if (base_addr[1:0] != 2'b00) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d      = base_addr;
            remaining_d = word_count;
            state_d     = S_ACCEPT;
          end
        end
      end

      S_ACCEPT: begin
        // in_ready is 1 throughout ACCEPT, so in_valid alone is a handshake.
        if (in_valid) begin
          if (out_of_range) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            data_d  = in_data;
            idx_d   = 2'd0;
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          addr_d      = addr_q + 32'd4;
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_ACCEPT;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // ---------------------------------------------------------------------------
  assign in_ready = (state_q == S_ACCEPT);
  assign mem_we   = (state_q == S_WRITE);
  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);
  assign error    = error_q;

  // Address and data are forced to zero outside WRITE so the port is quiet
  // when no write is happening.
  assign mem_addr = mem_we ? (addr_q + {30'b0, idx_q}) : 32'd0;

  always_comb begin
    mem_wdata = 8'd0;
    if (mem_we) begin
      case (idx_q)
        2'd0:    mem_wdata = data_q[31:24];
        2'd1:    mem_wdata = data_q[23:16];
        2'd2:    mem_wdata = data_q[15:8];
        default: mem_wdata = data_q[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A reference model computes, from the
// base address, word count and the words offered, which byte writes must
// appear, how many handshakes occur, and whether the load ends in done or
// error. A monitor records every byte write, handshake and done pulse with its
// cycle number, and each load is compared against the model, including the
// cycle relationships between handshake, writes, done and return to idle.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int MEM_SIZE = 511;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic             busy;
  logic             cpu_hold;
  logic             done;
  logic             error;

  imem_loader #(
    .MEM_SIZE (MEM_SIZE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  int n_vec  = 0;
  int n_miss = 0;

  // Byte memory filled from observed writes, used for fetch-style readback.
  logic [7:0]  bmem [0:MEM_SIZE-1];

  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];
  int          wr_c [$];
  int          hs_c [$];
  int          done_c [$];
  logic [31:0] words_q [$];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
      wr_c.push_back(cyc_g);
      if (mem_addr < 32'(MEM_SIZE)) bmem[mem_addr[8:0]] = mem_wdata;
    end
    if (in_valid && in_ready) hs_c.push_back(cyc_g);
    if (done) done_c.push_back(cyc_g);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_g);
    end
  endtask

  task automatic clr_mon();
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
    hs_c.delete();
    done_c.delete();
  endtask

  task automatic fill_random(input int cnt);
    words_q.delete();
    for (int i = 0; i < cnt; i++) words_q.push_back($urandom);
  endtask

  // One complete load: model, stimulus (in_valid offered every vper-th loop
  // cycle, dropped if not accepted), optional stray start at loop cycle inj,
  // then comparison against the model.
  task automatic run_load(input logic [31:0] base, input int cnt, input int vper,
                          input int inj, output int n_wr, output logic got_done,
                          output logic got_err);
    logic [31:0] exp_a [$];
    logic [7:0]  exp_d [$];
    int          exp_hs;
    logic        exp_done, exp_err, exp_rdy;
    int          sent, idle_cyc, t0, last_wr;
    logic        finished;

    // Reference model: words land at base+4w; the first word whose last byte
    // would sit past the end of memory aborts the load with nothing written.
    exp_hs   = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (base[1:0] != 2'b00) begin
      exp_err = 1'b1;
    end else if (cnt == 0) begin
      exp_done = 1'b1;
    end else begin
      exp_done = 1'b1;
      for (int w = 0; w < cnt; w++) begin
        longint a;
        a = longint'(base) + longint'(4 * w);
        exp_hs++;
        if (a + 3 > longint'(MEM_SIZE - 1)) begin
          exp_err  = 1'b1;
          exp_done = 1'b0;
          break;
        end
        for (int j = 0; j < 4; j++) begin
          exp_a.push_back(32'(a + j));
          exp_d.push_back(8'(words_q[w] >> (24 - 8 * j)));
        end
      end
    end
    exp_rdy = (base[1:0] == 2'b00) && (cnt != 0);

    clr_mon();
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(cnt);
    t0         = cyc_g;
    @(posedge clk); #1;
    start    = 1'b0;
    sent     = 0;
    finished = 1'b0;
    idle_cyc = 0;
    for (int k = 0; k < 600 && !finished; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      start = (k == inj);
      if (start) begin
        base_addr  = base ^ 32'h100;
        word_count = CNT_W'(9);
      end
      in_valid = (sent < cnt) && (k % vper == 0);
      in_data  = (sent < cnt) ? words_q[sent] : 32'h0;
      @(negedge clk);
      if (k == 0) begin
        chk("busy_at_T+1", longint'(busy), 1);
        chk("cpu_hold_at_T+1", longint'(cpu_hold), 1);
        chk("in_ready_at_T+1", longint'(in_ready), longint'(exp_rdy));
      end
      if (in_valid && in_ready) sent++;
      if (!busy) begin
        finished = 1'b1;
        idle_cyc = cyc_g;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;

    if (!finished) begin
      chk("load_timeout", 0, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end

    chk("num_writes", longint'(wr_a.size()), longint'(exp_a.size()));
    for (int i = 0; i < wr_a.size() && i < exp_a.size(); i++) begin
      chk("write_addr", longint'(wr_a[i]), longint'(exp_a[i]));
      chk("write_data", longint'(wr_d[i]), longint'(exp_d[i]));
      if (i / 4 < hs_c.size())
        chk("write_cycle", longint'(wr_c[i]), longint'(hs_c[i / 4] + 1 + i % 4));
    end
    chk("handshakes", longint'(hs_c.size()), longint'(exp_hs));
    chk("done_pulses", longint'(done_c.size()), exp_done ? 1 : 0);
    if (exp_done && done_c.size() == 1) begin
      last_wr = (wr_c.size() == 0) ? t0 : wr_c[wr_c.size() - 1];
      chk("done_cycle", longint'(done_c[0]), longint'(last_wr + 1));
      chk("idle_cycle", longint'(idle_cyc), longint'(done_c[0] + 1));
    end
    chk("error_flag", longint'(error), longint'(exp_err));

    n_wr     = wr_a.size();
    got_done = (done_c.size() != 0);
    got_err  = error;
    $display("load base=0x%08h count=%0d vper=%0d writes=%0d done=%0b error=%0b",
             base, cnt, vper, n_wr, got_done, got_err);
  endtask

  typedef struct {
    logic [31:0] base;
    int          cnt;
    int          vper;
    int          inj;
    int          exp_wr;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_wr;
    logic        got_done, got_err;
    logic        found;
    logic [31:0] rb;
    logic [31:0] rbase;
    int          rcnt, rinj;

    tbl[0] = '{32'h0000_0040, 3, 7, -1, 12, 1'b1, 1'b0};  // sparse in_valid
    tbl[1] = '{32'd504,       2, 1, -1,  4, 1'b0, 1'b1};  // second word off the end
    tbl[2] = '{32'd2,         1, 1, -1,  0, 1'b0, 1'b1};  // misaligned base
    tbl[3] = '{32'd0,         0, 1, -1,  0, 1'b1, 1'b0};  // empty load
    tbl[4] = '{32'd508,       1, 1, -1,  0, 1'b0, 1'b1};  // 508+3 = 511 too far
    tbl[5] = '{32'd500,       2, 2, -1,  8, 1'b1, 1'b0};  // ends exactly at 507
    tbl[6] = '{32'hFFFF_FFFC, 1, 1, -1,  0, 1'b0, 1'b1};  // would wrap past 2^32
    tbl[7] = '{32'h0000_0080, 2, 1,  3,  8, 1'b1, 1'b0};  // stray start mid-load
    tbl[8] = '{32'h0000_0100, 4, 3, -1, 16, 1'b1, 1'b0};

    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = 32'h0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_mem_we", longint'(mem_we), 0);
    chk("reset_mem_addr", longint'(mem_addr), 0);
    chk("reset_mem_wdata", longint'(mem_wdata), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_cpu_hold", longint'(cpu_hold), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_error", longint'(error), 0);

    // Basic load with fixed words, then fetch-style readback.
    words_q.delete();
    words_q.push_back(32'h8C01_0004);
    words_q.push_back(32'h0022_1820);
    run_load(32'h0, 2, 1, -1, n_wr, got_done, got_err);
    chk("basic_writes", longint'(n_wr), 8);
    rb = {bmem[0], bmem[1], bmem[2], bmem[3]};
    chk("readback_0", longint'(rb), 64'h8C01_0004);
    rb = {bmem[4], bmem[5], bmem[6], bmem[7]};
    chk("readback_4", longint'(rb), 64'h0022_1820);

    // Table of directed loads.
    for (int v = 0; v < 9; v++) begin
      fill_random(tbl[v].cnt);
      run_load(tbl[v].base, tbl[v].cnt, tbl[v].vper, tbl[v].inj, n_wr, got_done, got_err);
      chk("table_writes", longint'(n_wr), longint'(tbl[v].exp_wr));
      chk("table_done", longint'(got_done), longint'(tbl[v].exp_done));
      chk("table_error", longint'(got_err), longint'(tbl[v].exp_err));
    end

    // Reset in the middle of a word: abort on byte idx 2 (address 0x42).
    clr_mon();
    words_q.delete();
    words_q.push_back(32'hA1B2_C3D4);
    words_q.push_back(32'h1122_3344);
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = 32'h40;
    word_count = CNT_W'(2);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = words_q[0];
    found    = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 32'h42) begin
        found = 1'b1;
        chk("rst_byte2_data", longint'(mem_wdata), 64'hC3);
      end
    end
    chk("rst_reached_byte2", longint'(found), 1);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_mem_we", longint'(mem_we), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_cpu_hold", longint'(cpu_hold), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_writes_total", longint'(wr_a.size()), 3);
    chk("rst_idle_busy", longint'(busy), 0);
    $display("reset mid-load: writes before abort=%0d", wr_a.size());

    // Error stays sticky in IDLE, then a good start at 0x20 clears it.
    fill_random(1);
    run_load(32'd2, 1, 1, -1, n_wr, got_done, got_err);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("error_sticky", longint'(error), 1);
    fill_random(2);
    run_load(32'h20, 2, 1, -1, n_wr, got_done, got_err);
    chk("error_cleared", longint'(got_err), 0);
    chk("reload_writes", longint'(n_wr), 8);

    // Random loads against the model.
    for (int r = 0; r < 20; r++) begin
      rcnt  = $urandom_range(0, 4);
      rbase = 32'($urandom_range(0, 130) * 4);
      if ($urandom_range(0, 7) == 0) rbase = rbase + 32'd1;
      rinj = -1;
      if (rbase[1:0] == 2'b00 && rcnt >= 1 && rbase + 32'd3 <= 32'(MEM_SIZE - 1) &&
          $urandom_range(0, 2) == 0)
        rinj = 2;
      fill_random(rcnt);
      run_load(rbase, rcnt, $urandom_range(1, 8), rinj, n_wr, got_done, got_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
